// File: rtl/pwm_led_array.sv
// Multi-channel PWM LED driver: off/static/breathe/on modes, shared prescaler, boundary-synchronous updates.
// Optional build macro PWM_GAMMA_EN adds a registered quadratic gamma map (one extra CLK of LED latency).
module pwm_led_array #(
  parameter int CH_NUM  = 10,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 16,
  parameter int ADDR_W  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_we,
  input  logic [ADDR_W-1:0]  i_cfg_addr,
  input  logic [1:0]         i_cfg_mode,
  input  logic [CNT_W-1:0]   i_cfg_duty,
  input  logic [PRESC_W-1:0] i_presc,
  output logic [CH_NUM-1:0]  o_led,
  output logic               o_period_tick
);

  localparam logic [1:0]       MODE_OFF     = 2'b00;
  localparam logic [1:0]       MODE_STATIC  = 2'b01;
  localparam logic [1:0]       MODE_BREATHE = 2'b10;
  localparam logic [1:0]       MODE_ON      = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONES     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_ONES - CNT_W'(1);
  localparam logic [ADDR_W:0]  CH_LIM       = (ADDR_W+1)'(CH_NUM);

  logic [PRESC_W-1:0] r_pcnt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_period_tick;
  logic [CH_NUM-1:0]  r_led;

  logic [1:0]         r_sh_mode  [CH_NUM];
  logic [CNT_W-1:0]   r_sh_duty  [CH_NUM];
  logic [1:0]         r_act_mode [CH_NUM];
  logic [CNT_W-1:0]   r_act_duty [CH_NUM];
  logic [CNT_W-1:0]   r_level    [CH_NUM];
  logic [CH_NUM-1:0]  r_dir_down;

  logic               w_tick;
  logic               w_boundary;
  logic               w_addr_ok;
  logic [CNT_W-1:0]   w_lvl_nxt  [CH_NUM];
  logic [CH_NUM-1:0]  w_dir_nxt;
  logic [CNT_W-1:0]   w_e        [CH_NUM];

  // >= rather than == so a live PRESC drop below the running count wraps at once
  assign w_tick     = (r_pcnt >= i_presc);
  assign w_boundary = w_tick && (r_cnt == CNT_LAST);
  assign w_addr_ok  = ({1'b0, i_cfg_addr} < CH_LIM);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pcnt        <= '0;
      r_cnt         <= '0;
      r_period_tick <= 1'b0;
    end else begin
      r_period_tick <= w_boundary;
      if (w_tick) begin
        r_pcnt <= '0;
        r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
      end else begin
        r_pcnt <= r_pcnt + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_sh_mode[i] <= MODE_OFF;
        r_sh_duty[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (i_cfg_we && w_addr_ok && (i_cfg_addr == ADDR_W'(i))) begin
          r_sh_mode[i] <= i_cfg_mode;
          r_sh_duty[i] <= i_cfg_duty;
        end
      end
    end
  end

  // Breathe step evaluated against the mode/ceiling about to become active
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      w_lvl_nxt[i] = r_level[i];
      w_dir_nxt[i] = r_dir_down[i];
      if (r_sh_mode[i] == MODE_BREATHE) begin
        if (r_act_mode[i] != MODE_BREATHE) begin
          w_lvl_nxt[i] = '0;
          w_dir_nxt[i] = 1'b0;
        end else if (!r_dir_down[i]) begin
          if (r_level[i] >= r_sh_duty[i]) begin
            w_lvl_nxt[i] = r_sh_duty[i];
            w_dir_nxt[i] = 1'b1;
          end else begin
            w_lvl_nxt[i] = r_level[i] + CNT_W'(1);
          end
        end else begin
          if (r_level[i] == '0) begin
            w_dir_nxt[i] = 1'b0;
          end else if (r_level[i] > r_sh_duty[i]) begin
            w_lvl_nxt[i] = r_sh_duty[i];
          end else begin
            w_lvl_nxt[i] = r_level[i] - CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dir_down <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_act_mode[i] <= MODE_OFF;
        r_act_duty[i] <= '0;
        r_level[i]    <= '0;
      end
    end else if (w_boundary) begin
      r_dir_down <= w_dir_nxt;
      for (int i = 0; i < CH_NUM; i++) begin
        r_act_mode[i] <= r_sh_mode[i];
        r_act_duty[i] <= r_sh_duty[i];
        r_level[i]    <= w_lvl_nxt[i];
      end
    end
  end

  // Off/on fold into the compare as 0/all-ones, which give constant 0/1
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      case (r_act_mode[i])
        MODE_OFF:     w_e[i] = '0;
        MODE_STATIC:  w_e[i] = r_act_duty[i];
        MODE_BREATHE: w_e[i] = r_level[i];
        MODE_ON:      w_e[i] = CNT_ONES;
        default:      w_e[i] = '0;
      endcase
    end
  end

`ifdef PWM_GAMMA_EN
  function automatic logic [CNT_W-1:0] gamma_map(input logic [CNT_W-1:0] e);
    logic [2*CNT_W-1:0] sq;
    sq = (2*CNT_W)'(e) * (2*CNT_W)'(e);
    if (e == CNT_ONES) begin
      return CNT_ONES;
    end else begin
      return CNT_W'(sq >> CNT_W);
    end
  endfunction

  logic [CNT_W-1:0] r_gcmp [CH_NUM];
  logic [CNT_W-1:0] r_cnt_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_d <= '0;
      r_led   <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_gcmp[i] <= '0;
      end
    end else begin
      r_cnt_d <= r_cnt;
      for (int i = 0; i < CH_NUM; i++) begin
        r_gcmp[i] <= gamma_map(w_e[i]);
        r_led[i]  <= (r_cnt_d < r_gcmp[i]);
      end
    end
  end
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_led <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_led[i] <= (r_cnt < w_e[i]);
      end
    end
  end
`endif

  assign o_led         = r_led;
  assign o_period_tick = r_period_tick;

endmodule

// File: tb/tb_pwm_led_array.sv
// Randomized bench for pwm_led_array: per-period LED high-time and period length checked against a reference model.
module tb_pwm_led_array;

  localparam int CH = 2;
`ifdef PWM_GAMMA_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [0:0]  cfg_addr;
  logic [1:0]  cfg_mode;
  logic [3:0]  cfg_duty;
  logic [15:0] presc;
  logic [1:0]  led;
  logic        tick;
  logic [0:0]  led1;
  logic        tick1;

  always #5 clk = ~clk;

  pwm_led_array #(.CH_NUM(2), .CNT_W(4), .PRESC_W(16), .ADDR_W(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
    .i_cfg_mode(cfg_mode), .i_cfg_duty(cfg_duty), .i_presc(presc),
    .o_led(led), .o_period_tick(tick));

  pwm_led_array #(.CH_NUM(1), .CNT_W(4), .PRESC_W(16), .ADDR_W(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
    .i_cfg_mode(cfg_mode), .i_cfg_duty(cfg_duty), .i_presc(presc),
    .o_led(led1), .o_period_tick(tick1));

  int checks = 0;
  int failures = 0;

  // reference model state
  int sh_mode[CH], sh_duty[CH], act_mode[CH], act_duty[CH], lvl[CH];
  bit down[CH];
  bit pend;
  int pend_a, pend_m, pend_d;
  int acc[3], cur_exp[3], nxt_exp[3];
  int cur_m1, nxt_m1;
  bit win_open, seen_tick, tick_d, record;
  int skip, since_tick, n_win;
  int bq[$];

  task automatic chk_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gam(input int e);
`ifdef PWM_GAMMA_EN
    return (e == 15) ? 15 : ((e * e) >> 4);
`else
    return e;
`endif
  endfunction

  function automatic int exp_high(input int m, input int d, input int l, input int p);
    int e;
    case (m)
      0:       e = 0;
      1:       e = d;
      2:       e = l;
      default: e = 15;
    endcase
    return gam(e) * (p + 1);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      sh_mode[c] = 0; sh_duty[c] = 0; act_mode[c] = 0; act_duty[c] = 0;
      lvl[c] = 0; down[c] = 0;
    end
    for (int k = 0; k < 3; k++) begin
      acc[k] = 0; cur_exp[k] = 0; nxt_exp[k] = 0;
    end
    cur_m1 = 0; nxt_m1 = 0;
    pend = 0; win_open = 0; seen_tick = 0; tick_d = 0; skip = 0; since_tick = 0;
  endtask

  // one CLK: observe at negedge, advance the model, then drive the next input
  task automatic cycle(input bit do_wr, input int a, input int m, input int d, input bit rnd);
    bit close;
    int r;
    @(negedge clk);
    since_tick++;
    acc[0] += int'(led[0]);
    acc[1] += int'(led[1]);
    acc[2] += int'(led1[0]);
    if (tick) begin
      if (seen_tick && skip == 0) chk_eq("period_len", since_tick, 15 * (int'(presc) + 1));
      seen_tick = 1;
      since_tick = 0;
      for (int c = 0; c < CH; c++) begin
        if (sh_mode[c] == 2) begin
          if (act_mode[c] != 2) begin
            lvl[c] = 0; down[c] = 0;
          end else if (!down[c]) begin
            if (lvl[c] >= sh_duty[c]) begin lvl[c] = sh_duty[c]; down[c] = 1; end
            else lvl[c] = lvl[c] + 1;
          end else begin
            if (lvl[c] == 0) down[c] = 0;
            else if (lvl[c] > sh_duty[c]) lvl[c] = sh_duty[c];
            else lvl[c] = lvl[c] - 1;
          end
        end
        act_mode[c] = sh_mode[c];
        act_duty[c] = sh_duty[c];
        nxt_exp[c] = exp_high(act_mode[c], act_duty[c], lvl[c], int'(presc));
      end
      nxt_exp[2] = nxt_exp[0];
      nxt_m1 = act_mode[1];
    end
    close = (LAT == 0) ? tick : tick_d;
    if (close) begin
      if (win_open && skip == 0) begin
        chk_eq("ch0_high", acc[0], cur_exp[0]);
        chk_eq("ch1_high", acc[1], cur_exp[1]);
        chk_eq("ch1only_high", acc[2], cur_exp[2]);
        n_win++;
        if (record && cur_m1 == 2) bq.push_back(acc[1]);
      end
      if (skip > 0) skip--;
      for (int k = 0; k < 3; k++) begin
        acc[k] = 0; cur_exp[k] = nxt_exp[k];
      end
      cur_m1 = nxt_m1;
      win_open = 1;
    end
    tick_d = tick;
    if (pend) begin
      if (pend_a < CH) begin sh_mode[pend_a] = pend_m; sh_duty[pend_a] = pend_d; end
      pend = 0;
    end
    cfg_we = 1'b0;
    if (!do_wr && rnd && $urandom_range(0, 29) == 0) begin
      do_wr = 1;
      a = $urandom_range(0, 1);
      m = $urandom_range(0, 3);
      r = $urandom_range(0, 7);
      d = (r == 0) ? 0 : (r == 1) ? 15 : $urandom_range(0, 15);
    end
    if (do_wr) begin
      pend = 1; pend_a = a; pend_m = m; pend_d = d;
      cfg_we = 1'b1; cfg_addr = 1'(a); cfg_mode = 2'(m); cfg_duty = 4'(d);
    end
    if (rnd && $urandom_range(0, 399) == 0) begin
      presc = 16'($urandom_range(0, 3));
      skip = 2;
    end
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, rnd);
  endtask

  task automatic wr(input int a, input int m, input int d);
    cycle(1'b1, a, m, d, 1'b0);
  endtask

  initial begin
    int hi;
    int bref[10];
    bref = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 1'b0; cfg_mode = 2'b00; cfg_duty = 4'd0; presc = 16'd0;
    n_win = 0; record = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_eq("reset_led", int'(led), 0);
    chk_eq("reset_tick", int'(tick), 0);
    rst = 1'b0;

    // static duty 5 on ch0, breathe ceiling 3 on ch1
    wr(0, 1, 5);
    wr(1, 2, 3);
    record = 1;
    run(15 * 14, 1'b0);
    record = 0;
    chk_eq("breathe_windows", (bq.size() >= 10) ? 1 : 0, 1);
    for (int i = 0; i < 10 && i < bq.size(); i++) chk_eq("breathe_seq", bq[i], gam(bref[i]));

    // extremes and gamma probe value
    wr(0, 1, 15); run(45, 1'b0);
    wr(0, 1, 0);  run(45, 1'b0);
    wr(0, 3, 0);  run(45, 1'b0);
    wr(0, 0, 7);  run(45, 1'b0);
    wr(0, 1, 8);  run(45, 1'b0);
    run(7, 1'b0);
    wr(0, 1, 9);  run(45, 1'b0);

    // slower prescaler
    presc = 16'd2; skip = 2;
    run(45 * 5, 1'b0);
    presc = 16'd0; skip = 2;

    run(3000, 1'b1);

    // async reset mid-period with ch0 forced on
    presc = 16'd0; skip = 2;
    wr(0, 3, 0);
    run(60, 1'b0);
    chk_eq("pre_reset_led0", int'(led[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk_eq("async_rst_led", int'(led), 0);
    chk_eq("async_rst_tick", int'(tick), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 0, 0, 0, 1'b0);
      if (led != 2'b00 || led1 != 1'b0) hi++;
    end
    chk_eq("led_after_rst", hi, 0);
    run(60, 1'b0);

    chk_eq("windows_checked", (n_win >= 100) ? 1 : 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
